// File: rtl/pci_master_sched.sv
// Round-robin scheduler for the PCI core master port: one latched command in flight,
// retries re-requested after a backoff, watchdog-bounded XFER, one response per ack.
module pci_master_sched #(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 8,
  parameter int BACKOFF   = 4,
  parameter int TIMEOUT   = 1024,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [32*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ack,
  output logic              rsp_vld,
  output logic [IDW-1:0]    rsp_id,
  output logic [1:0]        rsp_code,
  output logic [31:0]       rsp_data,
  output logic              request,
  output logic              requesthold,
  output logic              complete,
  output logic              m_ready,
  output logic [3:0]        m_cbe,
  output logic              m_wrdn,
  output logic [31:0]       adio_in,
  input  logic [31:0]       adio_out,
  input  logic              m_data,
  input  logic              m_data_vld,
  input  logic              m_addr_n,
  input  logic [39:0]       csr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_BACKOFF, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d, id_q, id_d;
  logic           wr_q, wr_d;
  logic [31:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]     code_q, code_d;
  logic [7:0]     retry_cnt_q, retry_cnt_d;
  logic [15:0]    tmo_cnt_q, tmo_cnt_d;
  logic [3:0]     bo_cnt_q, bo_cnt_d;
  logic           m_dataq_q, fatal_q, retry_q, m_ready_q;
  logic           fell, found;
  logic [IDW-1:0] winner, idx;
  logic           unused_ok;

  assign fell        = ~m_data & m_dataq_q;
  assign requesthold = 1'b0;
  assign m_ready     = m_ready_q;
  assign unused_ok   = ^{csr[37], csr[35:0], addr_q[1:0]};

  // First requesting index after the last grant, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    code_d       = code_q;
    retry_cnt_d  = retry_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    bo_cnt_d     = bo_cnt_q;
    req_ack      = '0;
    rsp_vld      = 1'b0;
    request      = 1'b0;
    complete     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ack[winner] = ~reset;
          id_d    = winner;
          wr_d    = req_wr[winner];
          addr_d  = req_addr[32*int'(winner) +: 32];
          wdata_d = req_wdata[32*int'(winner) +: 32];
          rdata_d = 32'h0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        request   = 1'b1;
        tmo_cnt_d = 16'h0;
        state_d   = S_XFER;
      end
      S_XFER: begin
        complete  = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (m_data_vld && !wr_q) rdata_d = adio_out;
        if (fell) begin
          if (fatal_q) begin
            code_d  = 2'b10;
            state_d = S_RESP;
          end else if (retry_q && retry_cnt_q == 8'(MAX_RETRY - 1)) begin
            code_d  = 2'b01;
            state_d = S_RESP;
          end else if (retry_q) begin
            retry_cnt_d = retry_cnt_q + 8'd1;
            bo_cnt_d    = 4'h0;
            state_d     = S_BACKOFF;
          end else begin
            code_d  = 2'b00;
            state_d = S_RESP;
          end
        end else if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
          code_d  = 2'b11;
          state_d = S_RESP;
        end
      end
      S_BACKOFF: begin
        rdata_d = 32'h0;
        if (bo_cnt_q == 4'(BACKOFF - 1)) state_d = S_REQ;
        else bo_cnt_d = bo_cnt_q + 4'd1;
      end
      S_RESP: begin
        rsp_vld      = 1'b1;
        last_grant_d = id_q;
        retry_cnt_d  = 8'h0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_id   = rsp_vld ? id_q : '0;
  assign rsp_code = rsp_vld ? code_q : 2'b00;
  assign rsp_data = (rsp_vld && code_q == 2'b00 && !wr_q) ? rdata_q : 32'h0;

  assign m_cbe  = !m_addr_n ? {3'b011, wr_q} : 4'b0000;
  assign m_wrdn = (state_q != S_IDLE) & wr_q;

  always_comb begin
    adio_in = 32'h0;
    if (!m_addr_n) adio_in = {addr_q[31:2], 2'b00};
    else if (wr_q && m_data && state_q == S_XFER) adio_in = wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      wr_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      code_q       <= 2'b00;
      retry_cnt_q  <= 8'h0;
      tmo_cnt_q    <= 16'h0;
      bo_cnt_q     <= 4'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      code_q       <= code_d;
      retry_cnt_q  <= retry_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
    end
  end

  // Termination status: cleared by each address phase, sampled through the data phase.
  always_ff @(posedge CLK) begin
    if (reset) begin
      m_dataq_q <= 1'b0;
      fatal_q   <= 1'b0;
      retry_q   <= 1'b0;
      m_ready_q <= 1'b0;
    end else begin
      m_ready_q <= 1'b1;
      m_dataq_q <= m_data;
      if (!m_addr_n) begin
        fatal_q <= 1'b0;
        retry_q <= 1'b0;
      end else if (m_data) begin
        fatal_q <= csr[39] | csr[38];
        retry_q <= csr[36];
      end
    end
  end

endmodule

// File: doc/pci_master_sched.md
Name: pci_master_sched

Overview:
- Round-robin scheduler sharing the PCI core's single user-side master interface between NREQ local requesters.
- Latches one requester's single-dword read/write and sequences the core handshake (request, complete, address/data phases).
- Handles target retry with bounded re-issue and backoff, applies a watchdog, and returns one tagged response per accepted command.
- Sits between the DMA/register clients and the PCI core master port.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ).
- MAX_RETRY, 8, retry terminations tolerated before giving up (1..255).
- BACKOFF, 4, idle cycles between a retry and re-request (1..15).
- TIMEOUT, 1024, cycles allowed in XFER before abort (16..65535).

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_vld  in  NREQ  per-requester command valid; held until acked.
- req_wr  in  NREQ  1=write, 0=read.
- req_addr  in  32*NREQ  dword address, slice i = requester i.
- req_wdata  in  32*NREQ  write data.
- req_ack  out  NREQ  one-cycle pulse; command latched this cycle.
- rsp_vld  out  1  one-cycle response strobe.
- rsp_id  out  IDW  requester index of the response.
- rsp_code  out  2  00 ok, 01 retry exhausted, 10 fatal abort, 11 timeout.
- rsp_data  out  32  read data; 0 for writes or on error.
- request  out  1  core master request.
- requesthold  out  1  tied 0.
- complete  out  1  core transfer-in-progress indication.
- m_ready  out  1  master ready.
- m_cbe  out  4  command / byte enables.
- m_wrdn  out  1  direction to core.
- adio_in  out  32  address/write data to core.
- adio_out  in  32  read data from core.
- m_data  in  1  core data phase active.
- m_data_vld  in  1  core data valid this cycle.
- m_addr_n  in  1  core address phase, active low.
- csr  in  40  core status; [39],[38] abort bits, [36] retry bit.

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous, active-high, and every register is cleared on the CLK edge.
- Reset values: state IDLE; all outputs 0. last_grant = NREQ-1, so requester 0 wins first. Retry and timeout counters are 0.
- Reset mid-operation: return to IDLE with no rsp_vld. The accepted command is lost, and the requester must reissue it.
- m_ready: 0 in reset, 1 every cycle thereafter.
- Status flags:
  - m_dataq is a 1-cycle-delayed m_data; fell = ~m_data & m_dataq.
  - fatal and retry flags clear when m_addr_n=0.
  - While m_data=1: fatal <= csr[39]|csr[38]; retry <= csr[36].
- States: IDLE, REQ, XFER, BACKOFF, RESP.
  - IDLE: if any req_vld, the winner is the first set bit scanning from last_grant+1 with wrap. Pulse req_ack[winner]; latch id, wr, addr, wdata; go to REQ. Never ack in any other state.
  - REQ: request=1 for exactly one cycle, then XFER. Clear the timeout counter.
  - XFER: complete=1. Capture rdata <= adio_out when m_data_vld & ~wr. The timeout counter increments each cycle. Exits, in priority order:
    - fell & fatal -> RESP, code 10.
    - fell & retry & retry_cnt==MAX_RETRY-1 -> RESP, code 01.
    - fell & retry -> retry_cnt++, then BACKOFF.
    - fell -> RESP, code 00.
    - timeout counter reaches TIMEOUT-1 without fell -> RESP, code 11.
  - BACKOFF: wait exactly BACKOFF cycles, then REQ. The latched command is unchanged. rdata is cleared.
  - RESP: rsp_vld=1 for one cycle with rsp_id, rsp_code and rsp_data. rsp_data = rdata only if code 00 and ~wr, else 0. Set last_grant=id, clear retry_cnt, go to IDLE. A req_vld present during RESP is arbitrated in the following IDLE cycle.
- Core drive (combinational from latched command):
  - m_cbe = {3'b011, wr} when m_addr_n=0, else 4'b0000.
  - m_wrdn = wr while not IDLE, else 0.
  - adio_in = {addr[31:2],2'b00} when m_addr_n=0; = wdata when wr & m_data & state==XFER; else 0.
- Throughput: minimum 4 cycles from req_ack to rsp_vld plus core latency (IDLE, REQ, XFER…, RESP). One outstanding command at a time.
- Fairness: a requester holding req_vld waits at most NREQ-1 other commands.

Test Plan:
- Single read: req_vld[0]=1, addr 0x1000_0040, core returns adio_out=0xDEADBEEF on m_data_vld -> req_ack[0] one cycle; m_cbe=4'b0110 during m_addr_n=0; adio_in=0x1000_0040; rsp_vld with id 0, code 00, data 0xDEADBEEF.
- Write: req 2 writes 0x1234_5678 to 0x0000_0100 -> m_cbe=4'b0111 in address phase; adio_in=0x1234_5678 while m_data=1; rsp id 2, code 00, data 0.
- Round robin: req_vld=4'b1111 held continuously with each command acked -> grant order 0,1,2,3,0; req_vld=4'b1010 after last_grant=1 -> grant 3.
- Retry: csr[36]=1 on the first two data phases, then 0 -> request re-asserted exactly BACKOFF+1 cycles after each fell; final code 00. With csr[36] stuck at 1 -> code 01 after MAX_RETRY terminations.
- Fatal and timeout: csr[38]=1 during m_data -> code 10, no re-request. m_data never asserts -> code 11 TIMEOUT cycles after entering XFER.
- Reset in XFER: assert reset one cycle mid-transfer -> next cycle all outputs 0, no rsp_vld; next request is granted to requester 0.
